// File: rtl/load_store_queue.sv
// In-order load/store queue in front of a small reset-cleared data memory.
// The head op is serviced after MEM_LATENCY edges; each load produces a one-cycle result pulse.
module load_store_queue #(
  parameter int DEPTH       = 8,
  parameter int MEM_WORDS   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rw_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic [15:0] cntrl_in,
  input  logic [3:0]  Z_in,
  output logic [31:0] data_out,
  output logic [15:0] cntrl_out,
  output logic [3:0]  Z_out,
  output logic        stall_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MEM_LATENCY);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SVC_LAST   = SW'(MEM_LATENCY - 1);

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] idx;
    logic [31:0]   data;
    logic [15:0]   cntrl;
    logic [3:0]    z;
  } entry_t;

  entry_t        r_queue [DEPTH];
  logic [31:0]   r_mem   [MEM_WORDS];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_svc;

  entry_t        w_head;
  logic          w_full;
  logic          w_accept;
  logic          w_pop;
  logic          w_store_en;
  logic          w_unused_addr;

  assign w_full     = (r_count == COUNT_FULL);
  assign stall_out  = w_full;
  assign w_accept   = cntrl_in[0] && !w_full;
  assign w_pop      = (r_count != '0) && (r_svc == SVC_LAST);
  assign w_head     = r_queue[r_head];
  assign w_store_en = w_pop && w_head.rw && (w_head.z != 4'b0000);

  // Upper address bits alias onto the same words; the byte offset is irrelevant.
  assign w_unused_addr = ^{addr_in[31:AW+2], addr_in[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_svc     <= '0;
      data_out  <= '0;
      cntrl_out <= '0;
      Z_out     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge state.
      if (w_accept) r_tail <= r_tail + PW'(1);
      if (w_pop)    r_head <= r_head + PW'(1);

      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // The service counter only runs while an op sits at the head.
      if (r_count == '0 || w_pop) r_svc <= '0;
      else                        r_svc <= r_svc + SW'(1);

      data_out  <= '0;
      cntrl_out <= '0;
      Z_out     <= '0;
      if (w_pop && !w_head.rw) begin
        data_out  <= r_mem[w_head.idx];
        cntrl_out <= w_head.cntrl;
        Z_out     <= w_head.z;
      end
    end
  end

  // NOTE: queue payload is left unreset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_queue[r_tail] <= '{rw: rw_in, idx: addr_in[AW+1:2], data: data_in,
                           cntrl: cntrl_in, z: Z_in};
    end
  end

  // NOTE: this memory must come out of reset all-zero, so it is built from resettable flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_store_en) begin
      r_mem[w_head.idx] <= w_head.data;
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: an op-level model predicts every output each cycle,
// and literal expectations pin the key result timings and values.
module tb_load_store_queue;

  localparam int DEPTH       = 8;
  localparam int MEM_LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rw_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] data_in = '0;
  logic [15:0] cntrl_in = '0;
  logic [3:0]  Z_in = '0;
  logic [31:0] data_out;
  logic [15:0] cntrl_out;
  logic [3:0]  Z_out;
  logic        stall_out;

  load_store_queue #(.DEPTH(DEPTH), .MEM_WORDS(256), .MEM_LATENCY(MEM_LATENCY)) dut (
    .clk(clk), .rst(rst), .rw_in(rw_in), .addr_in(addr_in), .data_in(data_in),
    .cntrl_in(cntrl_in), .Z_in(Z_in), .data_out(data_out), .cntrl_out(cntrl_out),
    .Z_out(Z_out), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          comp;
    bit          is_load;
    logic [31:0] data;
    logic [15:0] cntrl;
    logic [3:0]  z;
  } pend_t;

  typedef struct {
    int          at;
    logic [31:0] data;
    logic [15:0] cntrl;
    logic [3:0]  z;
  } res_t;

  pend_t       pending[$];
  res_t        results[$];
  logic [31:0] model_mem [256];
  int          last_comp;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (edge %0d): got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic check_res(input string name, input int idx, input int at,
                           input logic [31:0] d, input logic [15:0] c, input logic [3:0] z);
    res_t r;
    r = '{at: -1, data: '0, cntrl: '0, z: '0};
    if (idx < results.size()) r = results[idx];
    check(name, {32'(r.at), r.cntrl, r.z, r.data}, {32'(at), c, z, d});
  endtask

  task automatic model_clear();
    pending.delete();
    last_comp = 0;
    foreach (model_mem[i]) model_mem[i] = '0;
  endtask

  // Ops run back to back in acceptance order, each taking MEM_LATENCY edges once it
  // reaches the front, so its completion edge follows from simple arithmetic.
  task automatic model_accept();
    pend_t p;
    int    base;
    int    idx;
    base      = (last_comp > cyc) ? last_comp : cyc;
    p.comp    = base + MEM_LATENCY;
    last_comp = p.comp;
    p.is_load = !rw_in;
    p.cntrl   = cntrl_in;
    p.z       = Z_in;
    idx       = int'(addr_in[9:2]);
    p.data    = '0;
    if (rw_in) begin
      if (Z_in != 4'h0) model_mem[idx] = data_in;
    end else begin
      p.data = model_mem[idx];
    end
    pending.push_back(p);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) model_clear();
    else if (cntrl_in[0] && pending.size() != DEPTH) model_accept();
  end

  initial forever begin
    logic [52:0] exp;
    @(negedge clk);
    exp = '0;
    foreach (pending[i])
      if (pending[i].comp == cyc && pending[i].is_load)
        exp[51:0] = {pending[i].z, pending[i].cntrl, pending[i].data};
    while (pending.size() > 0 && pending[0].comp <= cyc) void'(pending.pop_front());
    exp[52] = (pending.size() == DEPTH);
    check("outputs", 96'({stall_out, Z_out, cntrl_out, data_out}), 96'(exp));
    if (cntrl_out[0]) results.push_back('{at: cyc, data: data_out, cntrl: cntrl_out, z: Z_out});
  end

  task automatic put(input bit rw, input logic [31:0] a, input logic [31:0] d,
                     input logic [15:0] c, input logic [3:0] z, output int e);
    rw_in = rw; addr_in = a; data_in = d; cntrl_in = c; Z_in = z;
    e = cyc + 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cntrl_in = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int e0, e1, s;
    int exp_tags[$];
    model_clear();

    // Reset state, then a load of word 0 right after release.
    repeat (2) @(negedge clk);
    check("reset_outputs", 96'({stall_out, Z_out, cntrl_out, data_out}), 96'(0));
    #2 rst = 1'b1;
    @(negedge clk);
    results.delete();
    put(1'b0, 32'h0, 32'hFFFF_FFFF, 16'h0005, 4'h3, e0);
    idle(4);
    check("rst_load_count", 96'(results.size()), 96'(1));
    check_res("rst_load", 0, e0 + 2, 32'h0, 16'h0005, 4'h3);

    // Store then load of the same word.
    results.delete();
    put(1'b1, 32'h10, 32'hDEAD_BEEF, 16'h0001, 4'hF, e0);
    put(1'b0, 32'h10, 32'h0, 16'h0003, 4'hA, e1);
    idle(6);
    check("st_ld_count", 96'(results.size()), 96'(1));
    check_res("st_ld", 0, e0 + 4, 32'hDEAD_BEEF, 16'h0003, 4'hA);

    // A store with an all-zero lane mask leaves memory untouched.
    results.delete();
    put(1'b1, 32'h20, 32'h0000_1234, 16'h0001, 4'h0, e0);
    put(1'b0, 32'h20, 32'h0, 16'h0101, 4'hF, e1);
    idle(6);
    check("masked_count", 96'(results.size()), 96'(1));
    check_res("masked", 0, e0 + 4, 32'h0, 16'h0101, 4'hF);

    // Address 0x400 aliases onto word 0.
    results.delete();
    put(1'b1, 32'h400, 32'hCAFE_F00D, 16'h0001, 4'h1, e0);
    put(1'b0, 32'h000, 32'h0, 16'h0201, 4'h2, e1);
    idle(6);
    check("alias_count", 96'(results.size()), 96'(1));
    check_res("alias", 0, e0 + 4, 32'hCAFE_F00D, 16'h0201, 4'h2);

    // Valid op every cycle: the queue fills after 14 accepts, then every other request drops.
    results.delete();
    for (int i = 0; i < 20; i++) begin
      put(i % 4 == 0, 32'h40 + 32'(4 * (i % 2)), 32'(i) * 32'h0101_0101,
          {8'(i), 8'h01}, 4'hF, e0);
      if (i == 0) s = e0;
      if (i == 12) check("stall_low_at_7", 96'(stall_out), 96'(0));
      if (i == 13) check("stall_high_at_8", 96'(stall_out), 96'(1));
      if (i < 14 || i % 2 == 1)
        if (i % 4 != 0) exp_tags.push_back(i);
    end
    idle(40);
    check("full_count", 96'(results.size()), 96'(exp_tags.size()));
    foreach (exp_tags[k])
      check("full_order", 96'(k < results.size() ? results[k].cntrl : 16'h0),
            96'({8'(exp_tags[k]), 8'h01}));

    // Reset while ops are queued: nothing pending may complete or be written.
    for (int k = 0; k < 4; k++) put(1'b0, 32'h100, 32'h0, 16'h0501 + 16'(2 * k), 4'h5, e0);
    for (int k = 0; k < 3; k++) put(1'b0, 32'h30, 32'h0, 16'h0601 + 16'(2 * k), 4'h6, e0);
    put(1'b1, 32'h30, 32'h55AA_55AA, 16'h0607, 4'hF, e0);
    cntrl_in = '0;
    #2 rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("midrst_outputs", 96'({stall_out, Z_out, cntrl_out, data_out}), 96'(0));
    #2 rst = 1'b1;
    results.delete();
    idle(6);
    check("no_pulse_after_rst", 96'(results.size()), 96'(0));
    put(1'b0, 32'h30, 32'h0, 16'h0701, 4'hF, e0);
    put(1'b0, 32'h10, 32'h0, 16'h0703, 4'hF, e1);
    put(1'b0, 32'h0, 32'h0, 16'h0705, 4'hF, e1);
    idle(8);
    check("post_rst_count", 96'(results.size()), 96'(3));
    check_res("post_rst_0x30", 0, e0 + 2, 32'h0, 16'h0701, 4'hF);
    check_res("post_rst_0x10", 1, e0 + 4, 32'h0, 16'h0703, 4'hF);
    check_res("post_rst_0x00", 2, e0 + 6, 32'h0, 16'h0705, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
